// File: rtl/branch_predict_ctrl_if.sv
// Pipeline <-> branch predictor bundle: IF lookup, EX resolution/recovery, statistics.
// master = pipeline side, slave = branch_predict_ctrl.
interface branch_predict_ctrl_if;
  logic [31:0] PC_IF;
  logic        predict_br_IF;
  logic [31:0] predict_target_IF;
  logic        BHT_predict_IF;
  logic [31:0] PC_EX;
  logic        br_EX;
  logic        br_taken_EX;
  logic [31:0] br_target_EX;
  logic        predict_br_EX;
  logic        bubbleE;
  logic        flushD;
  logic        flushE;
  logic        redirect_EX;
  logic [31:0] redirect_PC;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  modport master (
    output PC_IF, PC_EX, br_EX, br_taken_EX, br_target_EX, predict_br_EX, bubbleE,
    input  predict_br_IF, predict_target_IF, BHT_predict_IF,
    input  flushD, flushE, redirect_EX, redirect_PC, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  PC_IF, PC_EX, br_EX, br_taken_EX, br_target_EX, predict_br_EX, bubbleE,
    output predict_br_IF, predict_target_IF, BHT_predict_IF,
    output flushD, flushE, redirect_EX, redirect_PC, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB (+ optional 2-bit BHT) with same-cycle misprediction recovery and counters.
// Define BRANCH_BHT_EN for 2-bit counters; default build is BTB-only.
module branch_predict_ctrl #(
  parameter int ENTRY_BITS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_ctrl_if.slave bp
);
  localparam int DEPTH = 1 << ENTRY_BITS;
  localparam int TAG_W = 30 - ENTRY_BITS;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
`ifdef BRANCH_BHT_EN
    logic [1:0]       ctr;
`endif
  } entry_t;

  function automatic entry_t reset_entry();
    entry_t e;
    e = '0;
`ifdef BRANCH_BHT_EN
    e.ctr = 2'd1;
`endif
    return e;
  endfunction

  entry_t                tbl_q [DEPTH];
  entry_t                if_ent, ex_ent, wr_ent;
  logic [ENTRY_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]      if_tag, ex_tag;
  logic                  if_hit, ex_hit, tbl_we;
  logic                  pred_if;
  logic                  resolve, actual, mispredict;
  logic [31:0]           branch_cnt_q, branch_cnt_d;
  logic [31:0]           mispredict_cnt_q, mispredict_cnt_d;

  assign if_idx = bp.PC_IF[ENTRY_BITS+1:2];
  assign if_tag = bp.PC_IF[31:ENTRY_BITS+2];
  assign ex_idx = bp.PC_EX[ENTRY_BITS+1:2];
  assign ex_tag = bp.PC_EX[31:ENTRY_BITS+2];
  assign if_ent = tbl_q[if_idx];
  assign ex_ent = tbl_q[ex_idx];
  assign if_hit = if_ent.valid && (if_ent.tag == if_tag);
  assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pred_if              = 1'b0;
    bp.BHT_predict_IF    = 1'b0;
    bp.predict_target_IF = '0;
`ifdef BRANCH_BHT_EN
    if (if_hit) begin
      pred_if           = if_ent.ctr[1];
      bp.BHT_predict_IF = if_ent.ctr[1];
    end
`else
    pred_if = if_hit;
`endif
    if (pred_if) bp.predict_target_IF = if_ent.target;
  end
  assign bp.predict_br_IF = pred_if;

  // Recovery is silenced during reset so the pipeline never sees a stray redirect.
  assign resolve    = rst_n && !bp.bubbleE;
  assign actual     = bp.br_EX && bp.br_taken_EX;
  assign mispredict = resolve && (bp.predict_br_EX != actual);

  assign bp.flushD      = mispredict;
  assign bp.flushE      = mispredict;
  assign bp.redirect_EX = mispredict;
  assign bp.redirect_PC = !mispredict ? '0 :
                          actual      ? bp.br_target_EX : (bp.PC_EX + 32'd4);

  always_comb begin
    tbl_we = 1'b0;
    wr_ent = ex_ent;
    if (resolve && bp.br_EX) begin
      if (actual) begin
        tbl_we = 1'b1;
`ifdef BRANCH_BHT_EN
        if (ex_hit) begin
          if (ex_ent.ctr != 2'd3) wr_ent.ctr = ex_ent.ctr + 2'd1;
          wr_ent.target = bp.br_target_EX;
        end else begin
          wr_ent        = '0;
          wr_ent.valid  = 1'b1;
          wr_ent.tag    = ex_tag;
          wr_ent.target = bp.br_target_EX;
          wr_ent.ctr    = 2'd2;
        end
`else
        wr_ent.valid  = 1'b1;
        wr_ent.tag    = ex_tag;
        wr_ent.target = bp.br_target_EX;
`endif
      end else if (ex_hit) begin
        tbl_we = 1'b1;
`ifdef BRANCH_BHT_EN
        if (ex_ent.ctr != 2'd0) wr_ent.ctr = ex_ent.ctr - 2'd1;
`else
        wr_ent.valid = 1'b0;
`endif
      end
    end else if (resolve && bp.predict_br_EX && ex_hit) begin
      // Something that is not a branch was predicted taken: drop the stale entry.
      tbl_we       = 1'b1;
      wr_ent.valid = 1'b0;
    end
  end

  assign branch_cnt_d     = branch_cnt_q + {31'd0, resolve && bp.br_EX};
  assign mispredict_cnt_d = mispredict_cnt_q + {31'd0, mispredict};

  // NOTE: the table is reset entry by entry because an asynchronous reset must empty it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= reset_entry();
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (tbl_we) tbl_q[ex_idx] <= wr_ent;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bp.branch_cnt     = branch_cnt_q;
  assign bp.mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: vector table through a scoreboard queue,
// plus hand sequences for hysteresis/BTB invalidation and asynchronous reset.
module tb_branch_predict_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl_if bp ();

  branch_predict_ctrl #(.ENTRY_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  typedef struct {
    logic [31:0] pc_if, pc_ex;
    logic        br, taken;
    logic [31:0] tgt;
    logic        pred_ex, bubble;
    logic        e_pred;
    logic [31:0] e_tgt;
    logic        e_flush;
    logic [31:0] e_rpc, e_bc, e_mc;
  } vec_t;

  typedef struct {
    string       name;
    logic        pred;
    logic [31:0] tgt;
    logic        flush;
    logic [31:0] rpc, bc, mc;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic [31:0] pc_if, input logic [31:0] pc_ex,
                              input logic br, input logic taken, input logic [31:0] tgt,
                              input logic pred_ex, input logic bubble,
                              input logic e_pred, input logic [31:0] e_tgt, input logic e_flush,
                              input logic [31:0] e_rpc, input logic [31:0] e_bc,
                              input logic [31:0] e_mc);
    vec_t v;
    v.pc_if = pc_if; v.pc_ex = pc_ex; v.br = br; v.taken = taken; v.tgt = tgt;
    v.pred_ex = pred_ex; v.bubble = bubble;
    v.e_pred = e_pred; v.e_tgt = e_tgt; v.e_flush = e_flush;
    v.e_rpc = e_rpc; v.e_bc = e_bc; v.e_mc = e_mc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bp.PC_IF         = v.pc_if;
    bp.PC_EX         = v.pc_ex;
    bp.br_EX         = v.br;
    bp.br_taken_EX   = v.taken;
    bp.br_target_EX  = v.tgt;
    bp.predict_br_EX = v.pred_ex;
    bp.bubbleE       = v.bubble;
  endtask

  task automatic compare_outputs(input exp_t e);
    logic e_bht;
`ifdef BRANCH_BHT_EN
    e_bht = e.pred;
`else
    e_bht = 1'b0;
`endif
    check({e.name, " predict_br_IF"},     {31'd0, bp.predict_br_IF},  {31'd0, e.pred});
    check({e.name, " predict_target_IF"}, bp.predict_target_IF,       e.tgt);
    check({e.name, " BHT_predict_IF"},    {31'd0, bp.BHT_predict_IF}, {31'd0, e_bht});
    check({e.name, " flushD"},            {31'd0, bp.flushD},         {31'd0, e.flush});
    check({e.name, " flushE"},            {31'd0, bp.flushE},         {31'd0, e.flush});
    check({e.name, " redirect_EX"},       {31'd0, bp.redirect_EX},    {31'd0, e.flush});
    check({e.name, " redirect_PC"},       bp.redirect_PC,             e.rpc);
    check({e.name, " branch_cnt"},        bp.branch_cnt,              e.bc);
    check({e.name, " mispredict_cnt"},    bp.mispredict_cnt,          e.mc);
  endtask

  // One cycle: drive after the edge, record expectations, compare on the falling edge.
  task automatic step(input string name, input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v);
    e.name = name; e.pred = v.e_pred; e.tgt = v.e_tgt; e.flush = v.e_flush;
    e.rpc = v.e_rpc; e.bc = v.e_bc; e.mc = v.e_mc;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s scoreboard: got empty queue, want one entry", name);
    end else begin
      compare_outputs(exp_q.pop_front());
    end
  endtask

  initial begin
    vec_t v;

    // Reset state, with EX inputs that would otherwise mispredict.
    drive(mk(32'h100, 32'h100, 1, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    begin
      exp_t e;
      e.name = "reset"; e.pred = 0; e.tgt = 0; e.flush = 0; e.rpc = 0; e.bc = 0; e.mc = 0;
      compare_outputs(e);
    end
    drive(mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    //              pc_if         pc_ex         br taken tgt          pe bub  pred tgt       fl rpc          bc mc
    vecs.push_back(mk(32'h100,      32'h0,        0, 0, 32'h0,      0, 0,   0, 32'h0,   0, 32'h0,      0, 0));
    vecs.push_back(mk(32'h100,      32'h100,      1, 1, 32'h80,     0, 0,   0, 32'h0,   1, 32'h80,     0, 0));
    vecs.push_back(mk(32'h100,      32'h0,        0, 0, 32'h0,      0, 0,   1, 32'h80,  0, 32'h0,      1, 1));
    vecs.push_back(mk(32'h104,      32'h0,        0, 0, 32'h0,      0, 0,   0, 32'h0,   0, 32'h0,      1, 1));
    vecs.push_back(mk(32'h100,      32'h100,      1, 1, 32'h80,     1, 0,   1, 32'h80,  0, 32'h0,      1, 1));
    vecs.push_back(mk(32'h100,      32'h0,        0, 0, 32'h0,      0, 0,   1, 32'h80,  0, 32'h0,      2, 1));
    vecs.push_back(mk(32'h100,      32'h200,      0, 0, 32'h0,      1, 0,   1, 32'h80,  1, 32'h204,    2, 1));
    vecs.push_back(mk(32'h100,      32'h0,        0, 0, 32'h0,      0, 0,   1, 32'h80,  0, 32'h0,      2, 2));
    vecs.push_back(mk(32'h100,      32'h100,      0, 0, 32'h0,      1, 0,   1, 32'h80,  1, 32'h104,    2, 2));
    vecs.push_back(mk(32'h100,      32'h0,        0, 0, 32'h0,      0, 0,   0, 32'h0,   0, 32'h0,      2, 3));
    vecs.push_back(mk(32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 32'h0,      1, 0,   0, 32'h0,   1, 32'h0,      2, 3));
    vecs.push_back(mk(32'hFFFFFFFC, 32'h0,        0, 0, 32'h0,      0, 0,   0, 32'h0,   0, 32'h0,      3, 4));
    vecs.push_back(mk(32'h300,      32'h300,      1, 1, 32'h400,    0, 1,   0, 32'h0,   0, 32'h0,      3, 4));
    vecs.push_back(mk(32'h300,      32'h300,      1, 1, 32'h400,    0, 1,   0, 32'h0,   0, 32'h0,      3, 4));
    vecs.push_back(mk(32'h300,      32'h300,      1, 1, 32'h400,    0, 1,   0, 32'h0,   0, 32'h0,      3, 4));
    vecs.push_back(mk(32'h300,      32'h300,      1, 1, 32'h400,    0, 0,   0, 32'h0,   1, 32'h400,    3, 4));
    vecs.push_back(mk(32'h300,      32'h0,        0, 0, 32'h0,      0, 0,   1, 32'h400, 0, 32'h0,      4, 5));
    vecs.push_back(mk(32'h300,      32'h500,      1, 0, 32'h0,      0, 0,   1, 32'h400, 0, 32'h0,      4, 5));
    vecs.push_back(mk(32'h500,      32'h0,        0, 0, 32'h0,      0, 0,   0, 32'h0,   0, 32'h0,      5, 5));
    vecs.push_back(mk(32'h0,        32'h100,      1, 1, 32'h80,     0, 0,   0, 32'h0,   1, 32'h80,     5, 5));
    vecs.push_back(mk(32'h100,      32'h140,      1, 1, 32'h900,    0, 0,   1, 32'h80,  1, 32'h900,    6, 6));
    vecs.push_back(mk(32'h100,      32'h0,        0, 0, 32'h0,      0, 0,   0, 32'h0,   0, 32'h0,      7, 7));
    vecs.push_back(mk(32'h140,      32'h0,        0, 0, 32'h0,      0, 0,   1, 32'h900, 0, 32'h0,      7, 7));

    for (int i = 0; i < vecs.size(); i++) step($sformatf("vec%0d", i), vecs[i]);

    // Direction training on a fresh entry, then not-taken outcomes.
    step("hyst_alloc", mk(32'h208, 32'h208, 1, 1, 32'h1000, 0, 0, 0, 32'h0,    1, 32'h1000, 7, 7));
    step("hyst_taken", mk(32'h208, 32'h208, 1, 1, 32'h1000, 1, 0, 1, 32'h1000, 0, 32'h0,    8, 8));
    step("hyst_nt1",   mk(32'h208, 32'h208, 1, 0, 32'h0,    1, 0, 1, 32'h1000, 1, 32'h20C,  9, 8));
`ifdef BRANCH_BHT_EN
    step("hyst_look1", mk(32'h208, 32'h0,   0, 0, 32'h0,    0, 0, 1, 32'h1000, 0, 32'h0,    10, 9));
    step("hyst_nt2",   mk(32'h208, 32'h208, 1, 0, 32'h0,    1, 0, 1, 32'h1000, 1, 32'h20C,  10, 9));
    step("hyst_look2", mk(32'h208, 32'h0,   0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,    11, 10));
`else
    step("btb_inval",  mk(32'h208, 32'h0,   0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 32'h0,    10, 9));
`endif

    // Asynchronous reset between edges while a hit and a mispredict are live.
    @(posedge clk);
    #3;
    drive(mk(32'h140, 32'h100, 1, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("pre_reset predict_br_IF", {31'd0, bp.predict_br_IF}, 32'd1);
    check("pre_reset flushD",        {31'd0, bp.flushD},        32'd1);
    rst_n = 1'b0;
    #1;
    begin
      exp_t e;
      e.name = "async_rst"; e.pred = 0; e.tgt = 0; e.flush = 0; e.rpc = 0; e.bc = 0; e.mc = 0;
      compare_outputs(e);
    end
    drive(mk(32'h140, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #2 rst_n = 1'b1;
    v = mk(32'h140, 32'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 0);
    step("post_rst_empty", v);
    step("post_rst_upd",   mk(32'h208, 32'h140, 1, 1, 32'h900, 0, 0, 0, 32'h0,   1, 32'h900, 0, 0));
    step("post_rst_hit",   mk(32'h140, 32'h0,   0, 0, 32'h0,   0, 0, 1, 32'h900, 0, 32'h0,   1, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
